ethernet_frame_rx: RTL and testbench

- Receive-side companion to the Ethernet frame generator; consumes its byte stream (tx_data looped to rx_data in loopback benches).
- Detects preamble/SFD and captures destination MAC, source MAC and length/type.
- Forwards payload bytes with the FCS stripped, and pad stripped for length-coded frames.
- Checks CRC-32 and min/max size, and reports one status pulse per frame.

---
 rtl/ethernet_frame_rx.sv | 212 +++++++++++++++++++++
 tb/tb_ethernet_frame_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_frame_rx.sv
// Ethernet frame receiver: preamble/SFD detection, header capture, payload
// forwarding with FCS and pad stripping, CRC-32 and frame size checking.
module ethernet_frame_rx #(
    parameter logic [7:0] SFD_BYTE  = 8'hAB,
    parameter logic [7:0] PRE_BYTE  = 8'h55,
    parameter int         MIN_FRAME = 64,
    parameter int         MAX_FRAME = 1518
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic [47:0] dest_mac,
    output logic [47:0] src_mac,
    output logic [15:0] len_type,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        size_err
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_CNT     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_CNT     = 11'(MAX_FRAME);
    localparam logic [15:0] LEN_MAX     = 16'd1500;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, MAC_DEST, MAC_SRC, LEN_TYPE, DATA, DROP, DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] byte_cnt_reg;
    logic [10:0] pay_cnt_reg;
    logic [2:0]  hdr_cnt_reg;
    logic [2:0]  buf_cnt_reg;
    logic [31:0] crc_reg;
    logic [31:0] crc_next;
    logic        oversize_reg;
    logic [47:0] dest_mac_reg, src_mac_reg;
    logic [15:0] len_type_reg;
    logic [7:0]  payload_data_reg;
    logic        payload_valid_reg;
    logic        frame_done_reg, frame_ok_reg, crc_err_reg, size_err_reg;

    logic        sfd_seen;
    logic        hdr_byte;
    logic        hdr_last;
    logic        data_byte;
    logic        oversize_hit;
    logic        emit;
    logic        runt;
    logic        crc_bad;
    logic [7:0]  oldest_byte;

    function automatic logic [31:0] crc_step(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rx_valid) state_next = (rx_data == PRE_BYTE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_valid)                  state_next = IDLE;
                else if (rx_data == SFD_BYTE)   state_next = MAC_DEST;
                else if (rx_data != PRE_BYTE)   state_next = DROP;
            end
            MAC_DEST: begin
                if (!rx_valid)     state_next = DONE;
                else if (hdr_last) state_next = MAC_SRC;
            end
            MAC_SRC: begin
                if (!rx_valid)     state_next = DONE;
                else if (hdr_last) state_next = LEN_TYPE;
            end
            LEN_TYPE: begin
                if (!rx_valid)     state_next = DONE;
                else if (hdr_last) state_next = DATA;
            end
            DATA: begin
                if (!rx_valid)                    state_next = DONE;
                else if (byte_cnt_reg == MAX_CNT) state_next = DROP;
            end
            DROP: begin
                if (!rx_valid) state_next = oversize_reg ? DONE : IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sfd_seen     = (state_reg == PREAMBLE) && rx_valid && (rx_data == SFD_BYTE);
    assign hdr_byte     = rx_valid && ((state_reg == MAC_DEST) || (state_reg == MAC_SRC) ||
                                       (state_reg == LEN_TYPE));
    assign hdr_last     = (state_reg == LEN_TYPE) ? (hdr_cnt_reg == 3'd1) : (hdr_cnt_reg == 3'd5);
    assign data_byte    = rx_valid && (state_reg == DATA) && (byte_cnt_reg != MAX_CNT);
    assign oversize_hit = rx_valid && (state_reg == DATA) && (byte_cnt_reg == MAX_CNT);
    // Length-coded frames stop emitting once len_type bytes are out; the rest is pad.
    assign emit         = data_byte && (buf_cnt_reg == 3'd4) &&
                          ((len_type_reg > LEN_MAX) || ({5'd0, pay_cnt_reg} < len_type_reg));
    assign crc_next     = crc_step(crc_reg, rx_data);
    assign runt         = byte_cnt_reg < MIN_CNT;
    assign crc_bad      = crc_reg != CRC_RESIDUE;

    // Four-deep shift buffer: the last four DATA bytes of a frame are the FCS.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf
            logic [7:0] byte_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clock) begin
                    if (reset)          byte_reg <= '0;
                    else if (data_byte) byte_reg <= rx_data;
                end
            end else begin : g_tail
                always_ff @(posedge clock) begin
                    if (reset)          byte_reg <= '0;
                    else if (data_byte) byte_reg <= g_buf[gi-1].byte_reg;
                end
            end
        end
    endgenerate
    assign oldest_byte = g_buf[3].byte_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            byte_cnt_reg      <= '0;
            pay_cnt_reg       <= '0;
            hdr_cnt_reg       <= '0;
            buf_cnt_reg       <= '0;
            crc_reg           <= 32'hFFFFFFFF;
            oversize_reg      <= 1'b0;
            dest_mac_reg      <= '0;
            src_mac_reg       <= '0;
            len_type_reg      <= '0;
            payload_data_reg  <= '0;
            payload_valid_reg <= 1'b0;
            frame_done_reg    <= 1'b0;
            frame_ok_reg      <= 1'b0;
            crc_err_reg       <= 1'b0;
            size_err_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            payload_valid_reg <= 1'b0;
            frame_done_reg    <= 1'b0;

            if (sfd_seen) begin
                byte_cnt_reg <= '0;
                pay_cnt_reg  <= '0;
                hdr_cnt_reg  <= '0;
                buf_cnt_reg  <= '0;
                crc_reg      <= 32'hFFFFFFFF;
                oversize_reg <= 1'b0;
            end

            if (hdr_byte) begin
                byte_cnt_reg <= byte_cnt_reg + 11'd1;
                crc_reg      <= crc_next;
                hdr_cnt_reg  <= hdr_last ? 3'd0 : hdr_cnt_reg + 3'd1;
                case (state_reg)
                    MAC_DEST: dest_mac_reg <= {dest_mac_reg[39:0], rx_data};
                    MAC_SRC:  src_mac_reg  <= {src_mac_reg[39:0], rx_data};
                    default:  len_type_reg <= {len_type_reg[7:0], rx_data};
                endcase
            end

            if (data_byte) begin
                byte_cnt_reg <= byte_cnt_reg + 11'd1;
                crc_reg      <= crc_next;
                if (buf_cnt_reg != 3'd4) buf_cnt_reg <= buf_cnt_reg + 3'd1;
            end

            if (emit) begin
                payload_data_reg  <= oldest_byte;
                payload_valid_reg <= 1'b1;
                pay_cnt_reg       <= pay_cnt_reg + 11'd1;
            end

            if (oversize_hit) oversize_reg <= 1'b1;

            // Status is latched on entry to DONE so frame_done is high during DONE.
            if (state_next == DONE) begin
                frame_done_reg <= 1'b1;
                size_err_reg   <= oversize_reg | runt;
                crc_err_reg    <= ~(oversize_reg | runt) & crc_bad;
                frame_ok_reg   <= ~(oversize_reg | runt) & ~crc_bad;
            end

            if (state_reg == DONE) oversize_reg <= 1'b0;
        end
    end

    assign payload_data  = payload_data_reg;
    assign payload_valid = payload_valid_reg;
    assign dest_mac      = dest_mac_reg;
    assign src_mac       = src_mac_reg;
    assign len_type      = len_type_reg;
    assign frame_done    = frame_done_reg;
    assign frame_ok      = frame_ok_reg;
    assign crc_err       = crc_err_reg;
    assign size_err      = size_err_reg;
endmodule

// File: tb/tb_ethernet_frame_rx.sv
// Scoreboard bench for ethernet_frame_rx: directed and random frames are
// checked against a frame-level reference model.
module tb_ethernet_frame_rx;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] len_type;
    logic        frame_done, frame_ok, crc_err, size_err;

    ethernet_frame_rx dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .payload_data(payload_data), .payload_valid(payload_valid),
        .dest_mac(dest_mac), .src_mac(src_mac), .len_type(len_type),
        .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err), .size_err(size_err)
    );

    always #5 clock = ~clock;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        ok, crc, size, chk_hdr;
        logic [47:0] dest, src;
        logic [15:0] len;
    } stat_t;

    logic [7:0] exp_pay[$];
    stat_t      exp_stat[$];
    int         tests = 0;
    int         fails = 0;
    int         frame_no = 0;

    function automatic logic [31:0] fcs_of(bq_t b, int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t build(logic [47:0] d, logic [47:0] s, logic [15:0] l, bq_t pay);
        bq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) f.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(s[47-8*i -: 8]);
        f.push_back(l[15:8]);
        f.push_back(l[7:0]);
        foreach (pay[i]) f.push_back(pay[i]);
        fcs = fcs_of(f, f.size());
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    // Frame-level expectations: accepted bytes are capped at 1518, the last
    // four accepted data bytes are FCS, and short length fields trim pad.
    task automatic model(bq_t f);
        int n, acc, dn, em;
        stat_t st;
        logic [15:0] l;
        n   = f.size();
        acc = (n > 1518) ? 1518 : n;
        dn  = (acc > 14) ? acc - 14 : 0;
        em  = (dn > 4) ? dn - 4 : 0;
        l   = (n >= 14) ? {f[12], f[13]} : 16'h0000;
        if (l <= 16'd1500 && int'(l) < em) em = int'(l);
        for (int i = 0; i < em; i++) exp_pay.push_back(f[14+i]);
        st.size    = (n < 64) || (n > 1518);
        st.crc     = !st.size && ((n < 4) ||
                     (fcs_of(f, n-4) != {f[n-1], f[n-2], f[n-3], f[n-4]}));
        st.ok      = !st.size && !st.crc;
        st.chk_hdr = (n >= 14);
        st.dest    = (n >= 14) ? {f[0], f[1], f[2], f[3], f[4], f[5]} : 48'd0;
        st.src     = (n >= 14) ? {f[6], f[7], f[8], f[9], f[10], f[11]} : 48'd0;
        st.len     = l;
        exp_stat.push_back(st);
    endtask

    task automatic drive(logic [7:0] b);
        @(posedge clock); #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(int n);
        @(posedge clock); #1;
        rx_valid = 1'b0;
        repeat (n) @(posedge clock);
    endtask

    task automatic send_frame(int npre, bq_t f, int gap);
        model(f);
        for (int i = 0; i < npre; i++) drive(8'h55);
        drive(8'hAB);
        foreach (f[i]) drive(f[i]);
        idle(gap);
    endtask

    task automatic send_raw(bq_t b, int gap);
        foreach (b[i]) drive(b[i]);
        idle(gap);
    endtask

    function automatic bq_t seq_bytes(int n, int start);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(start + i));
        return q;
    endfunction

    function automatic bq_t rand_bytes(int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Monitor: pops scoreboard entries whenever the DUT presents output.
    initial begin
        forever begin
            @(negedge clock);
            if (payload_valid) begin
                tests++;
                if (exp_pay.size() == 0) begin
                    fails++;
                    $display("FAIL payload_unexpected: got %02h, expected no payload", payload_data);
                end else begin
                    logic [7:0] e;
                    e = exp_pay.pop_front();
                    if (payload_data !== e) begin
                        fails++;
                        $display("FAIL payload_byte: got %02h, expected %02h", payload_data, e);
                    end
                end
            end
            if (frame_done) begin
                tests++;
                frame_no++;
                if (exp_stat.size() == 0) begin
                    fails++;
                    $display("FAIL frame_done_unexpected: ok=%0b crc=%0b size=%0b, expected none",
                             frame_ok, crc_err, size_err);
                end else begin
                    stat_t s;
                    s = exp_stat.pop_front();
                    $display("[TB] frame %0d: ok=%0b crc_err=%0b size_err=%0b dest=%012h src=%012h len=%04h",
                             frame_no, frame_ok, crc_err, size_err, dest_mac, src_mac, len_type);
                    if ({frame_ok, crc_err, size_err} !== {s.ok, s.crc, s.size}) begin
                        fails++;
                        $display("FAIL frame_status: got ok/crc/size=%b%b%b, expected %b%b%b",
                                 frame_ok, crc_err, size_err, s.ok, s.crc, s.size);
                    end
                    if (s.chk_hdr) begin
                        tests++;
                        if ({dest_mac, src_mac, len_type} !== {s.dest, s.src, s.len}) begin
                            fails++;
                            $display("FAIL header: got %012h %012h %04h, expected %012h %012h %04h",
                                     dest_mac, src_mac, len_type, s.dest, s.src, s.len);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bq_t f, pay;
        logic [47:0] d0 = 48'h010203040506;
        logic [47:0] s0 = 48'h0A0B0C0D0E0F;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({payload_valid, frame_done, frame_ok, crc_err, size_err} !== 5'b0 ||
            dest_mac !== 48'd0 || src_mac !== 48'd0 || len_type !== 16'd0 || payload_data !== 8'd0) begin
            fails++;
            $display("FAIL reset_state: got pv=%0b fd=%0b ok=%0b dest=%012h len=%04h, expected all zero",
                     payload_valid, frame_done, frame_ok, dest_mac, len_type);
        end

        // Basic frame, then pad-trimmed, then bad FCS.
        pay = seq_bytes(46, 0);
        send_frame(7, build(d0, s0, 16'h002E, pay), 3);
        send_frame(7, build(d0, s0, 16'h0005, pay), 3);
        f = build(d0, s0, 16'h002E, pay);
        f[f.size()-1] = f[f.size()-1] ^ 8'h01;
        send_frame(7, f, 3);

        // Runt of 40 bytes, and a frame ending inside the header.
        send_frame(2, build(d0, s0, 16'd22, seq_bytes(22, 100)), 2);
        f = seq_bytes(10, 200);
        send_frame(1, f, 2);

        // Oversize: 1600 bytes after SFD.
        send_frame(7, build(d0, s0, 16'h0800, rand_bytes(1582)), 3);

        // Preamble broken by a stray byte, junk without preamble, then a good frame.
        f = '{8'h55, 8'h55, 8'h12, 8'h34, 8'h56};
        send_raw(f, 3);
        f = '{8'h12, 8'h55, 8'hAB, 8'h00};
        send_raw(f, 3);
        send_frame(7, build(d0, s0, 16'h002E, pay), 3);

        // Reset mid-payload: ten data bytes in, so six have been forwarded.
        f = build(d0, s0, 16'h0800, seq_bytes(60, 50));
        for (int i = 0; i < 6; i++) exp_pay.push_back(f[14+i]);
        for (int i = 0; i < 7; i++) drive(8'h55);
        drive(8'hAB);
        for (int i = 0; i < 24; i++) drive(f[i]);
        drive(f[24]);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        send_frame(7, build(s0, d0, 16'h0800, seq_bytes(50, 7)), 3);

        // Randomized frames across length-coded, padded, type-coded and gap lengths.
        for (int t = 0; t < 16; t++) begin
            int mode, plen;
            logic [15:0] l;
            mode = $urandom_range(0, 3);
            plen = $urandom_range(46, 120);
            case (mode)
                0: l = 16'(plen);
                1: begin l = 16'($urandom_range(1, 45)); plen = 46; end
                2: l = 16'h0800;
                default: l = 16'($urandom_range(1501, 1535));
            endcase
            f = build({$urandom(), $urandom()} >> 16, {$urandom(), $urandom()} >> 16, l, rand_bytes(plen));
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, f.size() - 1);
                f[p] = f[p] ^ 8'(1 << $urandom_range(0, 7));
            end
            send_frame($urandom_range(1, 8), f, $urandom_range(2, 5));
        end

        repeat (20) @(posedge clock);
        tests++;
        if (exp_pay.size() != 0) begin
            fails++;
            $display("FAIL payload_drain: got %0d bytes outstanding, expected 0", exp_pay.size());
        end
        tests++;
        if (exp_stat.size() != 0) begin
            fails++;
            $display("FAIL frame_drain: got %0d frames outstanding, expected 0", exp_stat.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
